// File: rtl/alu_shift_seq_if.sv
// Request/response bundle for the iterative shift sequencer.
//
// Both channels use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high. The source holds valid and its
// payload stable until that edge; ready may change freely and never
// depends on valid in the same cycle.
interface alu_shift_seq_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [DATA_WIDTH-1:0] rs1_data_i;
   logic [DATA_WIDTH-1:0] rs2_data_i;
   logic [DATA_WIDTH-1:0] imm_i;
   logic                  use_imm_i;
   logic [1:0]            op_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  err_o;
   logic                  busy_o;

   // Issue side: presents requests, consumes results.
   modport master (
      output req_valid_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i, op_i,
      output rsp_ready_i,
      input  req_ready_o, rsp_valid_o, result_o, err_o, busy_o
   );

   // Sequencer side.
   modport slave (
      input  req_valid_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i, op_i,
      input  rsp_ready_i,
      output req_ready_o, rsp_valid_o, result_o, err_o, busy_o
   );
endinterface

// File: rtl/alu_shift_seq.sv
// Multi-cycle shifter: SLL/SRL/SRA applied at most STEP bit positions per
// clock, replacing a single-cycle barrel shifter where area matters.
// Optional feature macro: ALU_SHIFT_ROTATE_EN makes op 2'b11 a rotate
// right; without it op 2'b11 is illegal and passes rs1 through with err_o.
// dbg_state_o exposes the FSM state (IDLE=0, BUSY=1, DONE=2).
module alu_shift_seq #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHIFT_WIDTH = 5,
   parameter int STEP        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_shift_seq_if.slave        bus,
   output logic [1:0]            dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [1:0]             OP_SLL = 2'b00;
   localparam logic [1:0]             OP_SRL = 2'b01;
   localparam logic [1:0]             OP_SRA = 2'b10;
   localparam logic [SHIFT_WIDTH-1:0] STEP_W = SHIFT_WIDTH'(STEP);

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   work_q, work_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [SHIFT_WIDTH-1:0]  rem_q, rem_d;
   logic [1:0]              op_q, op_d;

   logic [DATA_WIDTH-1:0]   amt_src;
   logic [SHIFT_WIDTH-1:0]  amt;
   logic [SHIFT_WIDTH-1:0]  step_s;
   logic [DATA_WIDTH-1:0]   shifted;
   logic                    req_ready;
   logic                    rsp_valid;
   logic                    busy;
   logic                    unused_amt_hi;

`ifdef ALU_SHIFT_ROTATE_EN
   logic [SHIFT_WIDTH:0]    rot_l;
`endif

   // Op 2'b11 is only legal when the rotate feature is built in.
   function automatic logic op_illegal(input logic [1:0] op);
`ifdef ALU_SHIFT_ROTATE_EN
      op_illegal = 1'b0 & op[0];
`else
      op_illegal = (op == 2'b11);
`endif
   endfunction

   // Shift amount comes from the low SHIFT_WIDTH bits of the selected source.
   assign amt_src       = bus.use_imm_i ? bus.imm_i : bus.rs2_data_i;
   assign amt           = amt_src[SHIFT_WIDTH-1:0];
   assign unused_amt_hi = ^amt_src[DATA_WIDTH-1:SHIFT_WIDTH];

   // One iteration of the datapath: shift the work register by min(rem, STEP).
   always_comb begin
      step_s  = (rem_q < STEP_W) ? rem_q : STEP_W;
      shifted = work_q;
`ifdef ALU_SHIFT_ROTATE_EN
      rot_l   = (SHIFT_WIDTH+1)'(DATA_WIDTH) - {1'b0, step_s};
`endif
      case (op_q)
         OP_SLL:  shifted = work_q << step_s;
         OP_SRL:  shifted = work_q >> step_s;
         OP_SRA:  shifted = $unsigned($signed(work_q) >>> step_s);
         default: begin
`ifdef ALU_SHIFT_ROTATE_EN
            shifted = (work_q >> step_s) | (work_q << rot_l);
`else
            shifted = work_q;
`endif
         end
      endcase
   end

   // Next-state and handshake outputs for the IDLE/BUSY/DONE sequencer.
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      result_d  = result_q;
      rem_d     = rem_q;
      op_d      = op_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) begin
               work_d = bus.rs1_data_i;
               op_d   = bus.op_i;
               rem_d  = amt;
               // Nothing to iterate: answer directly with the operand.
               if (amt == '0 || op_illegal(bus.op_i)) begin
                  state_d  = S_DONE;
                  result_d = bus.rs1_data_i;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            busy   = 1'b1;
            work_d = shifted;
            rem_d  = rem_q - step_s;
            if (rem_q == step_s) begin
               state_d  = S_DONE;
               result_d = shifted;
            end
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            // No same-cycle accept here: IDLE presents ready next cycle.
            if (bus.rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         work_q   <= '0;
         result_q <= '0;
         rem_q    <= '0;
         op_q     <= '0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         op_q     <= op_d;
      end
   end

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.busy_o      = busy;
   assign bus.result_o    = result_q;
   assign bus.err_o       = (state_q == S_DONE) && op_illegal(op_q);
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq: directed cases plus randomized
// requests against a behavioural shift model.
// Honors ALU_SHIFT_ROTATE_EN the same way as the design.
module tb_alu_shift_seq;

   localparam int DW   = 32;
   localparam int SW   = 5;
   localparam int STEP = 4;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   alu_shift_seq_if #(.DATA_WIDTH(DW)) bus ();

   alu_shift_seq #(
      .DATA_WIDTH  (DW),
      .SHIFT_WIDTH (SW),
      .STEP        (STEP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: full shift by amt in one go, {err, result}.
   function automatic logic [DW:0] model(input logic [1:0] op, input logic [DW-1:0] a, input int amt);
      logic [DW-1:0] r;
      logic          e;
      e = 1'b0;
      case (op)
         2'b00: r = a << amt;
         2'b01: r = a >> amt;
         2'b10: r = $signed(a) >>> amt;
         default: begin
`ifdef ALU_SHIFT_ROTATE_EN
            r = (amt == 0) ? a : ((a >> amt) | (a << (DW - amt)));
`else
            r = a;
            e = 1'b1;
`endif
         end
      endcase
      return {e, r};
   endfunction

   function automatic int model_latency(input logic [1:0] op, input int amt);
      logic [DW:0] m;
      m = model(op, '0, amt);
      if (amt == 0 || m[DW]) return 1;
      return 1 + (amt + STEP - 1) / STEP;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs();
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
      bus.imm_i      = $urandom;
      bus.use_imm_i  = 1'(($urandom_range(0, 1)));
      bus.op_i       = 2'($urandom_range(0, 3));
   endtask

   // Driver: issue one request, follow it to DONE, apply bp cycles of
   // backpressure, then complete the response handshake.
   task automatic do_txn(input logic [1:0] op, input logic [DW-1:0] rs1,
                         input logic [DW-1:0] rs2, input logic [DW-1:0] imm,
                         input logic use_imm, input int bp);
      logic [DW-1:0] exp_q[$];
      logic [DW:0]   m;
      logic [DW-1:0] sel;
      int            amt;
      int            lat;
      int            k;
      sel = use_imm ? imm : rs2;
      amt = int'(sel[SW-1:0]);
      m   = model(op, rs1, amt);
      lat = model_latency(op, amt);
      exp_q.push_back(m[DW-1:0]);
      exp_q.push_back({31'd0, m[DW]});

      bus.op_i = op; bus.rs1_data_i = rs1; bus.rs2_data_i = rs2;
      bus.imm_i = imm; bus.use_imm_i = use_imm; bus.req_valid_i = 1'b1;
      check("req_ready_idle", bus.req_ready_o, 1);
      tick();
      bus.req_valid_i = 1'b0;
      k = 1;
      while (!bus.rsp_valid_o && k < 40) begin
         check("busy_high", bus.busy_o, 1);
         scramble_inputs();
         bus.req_valid_i = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      check("rsp_valid", bus.rsp_valid_o, 1);
      check("latency", k, lat);
      check("result", bus.result_o, exp_q[0]);
      check("err", bus.err_o, exp_q[1]);
      check("busy_done", bus.busy_o, 0);
      check("req_ready_done", bus.req_ready_o, 0);
      for (int i = 0; i < bp; i++) begin
         scramble_inputs();
         bus.req_valid_i = 1'b1;
         tick();
         check("bp_valid", bus.rsp_valid_o, 1);
         check("bp_result", bus.result_o, exp_q[0]);
         check("bp_err", bus.err_o, exp_q[1]);
         check("bp_req_ready", bus.req_ready_o, 0);
      end
      bus.req_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      check("valid_drop", bus.rsp_valid_o, 0);
      check("req_ready_back", bus.req_ready_o, 1);
      check("result_held", bus.result_o, exp_q[0]);
   endtask

   initial begin : main
      int seen;
      rst = 1'b1;
      bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
      bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.imm_i = '0;
      bus.use_imm_i = 1'b0; bus.op_i = 2'b00;
      repeat (3) tick();
      check("rst_req_ready", bus.req_ready_o, 1);
      check("rst_rsp_valid", bus.rsp_valid_o, 0);
      check("rst_result", bus.result_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_busy", bus.busy_o, 0);
      rst = 1'b0;
      tick();

      // directed cases
      do_txn(2'b00, 32'h0000_0001, 32'd5, 32'd0, 1'b0, 0);
      do_txn(2'b10, 32'h8000_0000, 32'd0, 32'd31, 1'b1, 0);
      do_txn(2'b01, 32'h8000_0000, 32'd0, 32'd31, 1'b1, 0);
      do_txn(2'b00, 32'hDEAD_BEEF, 32'h0000_0020, 32'd0, 1'b0, 0);
      do_txn(2'b00, 32'h0000_0001, 32'h0000_0023, 32'd0, 1'b0, 0);
      do_txn(2'b01, 32'h1234_5678, 32'd4, 32'd0, 1'b0, 3);
      do_txn(2'b11, 32'h0000_00F1, 32'd4, 32'd0, 1'b0, 0);
      do_txn(2'b11, 32'h0000_00F1, 32'd0, 32'd4, 1'b1, 2);

      // reset mid-operation: SLL amt=31 accepted in cycle C
      bus.op_i = 2'b00; bus.rs1_data_i = 32'h1; bus.rs2_data_i = 32'd31;
      bus.use_imm_i = 1'b0; bus.req_valid_i = 1'b1;
      tick();
      bus.req_valid_i = 1'b0;
      tick();
      tick();
      check("mid_busy", bus.busy_o, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_ready", bus.req_ready_o, 1);
      check("mid_rst_valid", bus.rsp_valid_o, 0);
      check("mid_rst_result", bus.result_o, 0);
      check("mid_rst_busy", bus.busy_o, 0);
      check("mid_rst_err", bus.err_o, 0);
      rst = 1'b0;
      seen = 0;
      bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.rsp_valid_o) seen++;
      end
      bus.rsp_ready_i = 1'b0;
      check("no_rsp_after_rst", seen, 0);

      // randomized requests
      for (int t = 0; t < 60; t++) begin
         do_txn(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
Multi-cycle sequencer that drives an iterative shift datapath, applying at most STEP bit positions per clock.
It accepts one shift request at a time over a valid/ready handshake and returns the result over a second valid/ready handshake.
It sits between the issue stage and writeback. It takes the place of a full single-cycle barrel shifter when area matters more than latency.
Supported ops: SLL, SRL and SRA, register or immediate amount. Rotate is optional.

Parameters:
DATA_WIDTH, 32, operand and result width.
SHIFT_WIDTH, 5, number of amount bits used; equals log2(DATA_WIDTH).
STEP, 4, maximum bit positions shifted per BUSY cycle; legal range 1..DATA_WIDTH-1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
req_valid_i  in  1  request valid.
req_ready_o  out  1  sequencer can accept a request.
rs1_data_i  in  DATA_WIDTH  value to shift.
rs2_data_i  in  DATA_WIDTH  register shift amount.
imm_i  in  DATA_WIDTH  immediate shift amount.
use_imm_i  in  1  1 selects imm_i as the amount, 0 selects rs2_data_i.
op_i  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROR (optional) or illegal.
rsp_valid_o  out  1  result valid.
rsp_ready_i  in  1  consumer accepts the result.
result_o  out  DATA_WIDTH  shifted value.
err_o  out  1  illegal op; qualified by rsp_valid_o.
busy_o  out  1  high while in state BUSY.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state: IDLE.
- Reset values: req_ready_o=1, rsp_valid_o=0, result_o=0, err_o=0, busy_o=0. Internal operand register, remaining count and op register all clear to 0.
- amt = low SHIFT_WIDTH bits of the selected source. Upper bits are ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_ready_o=1.
  - Accept occurs when req_valid_i && req_ready_o at a clock edge.
  - On accept: latch rs1_data_i into the work register, latch op_i, set rem=amt.
  - Next state is DONE if amt==0 or op is illegal; otherwise BUSY.
- BUSY:
  - req_ready_o=0, busy_o=1.
  - Each edge shifts the work register by s=min(rem,STEP), then rem-=s.
  - SLL fills with 0. SRL fills with 0. SRA fills with the current MSB.
  - When rem reaches 0, go to DONE.
- DONE:
  - rsp_valid_o=1. result_o = work register, err_o per latched op.
  - All outputs are held stable while rsp_ready_i=0.
  - On rsp_valid_o && rsp_ready_i, go to IDLE.
  - req_ready_o returns 1 in the following cycle. There is no same-cycle accept from DONE.
- Latency: if accept happens in cycle C, rsp_valid_o rises in cycle C+1+ceil(amt/STEP).
- Illegal op: result_o = rs1 unchanged, err_o=1, and the response is given at C+1.
- Input changes while not in IDLE are ignored. The operands are captured only at accept.
- rst asserted in any state takes effect at the next edge:
  - state returns to IDLE and all outputs take their reset values;
  - any in-flight request is dropped and no response is emitted.
- result_o is held from the end of DONE until the next result is loaded. It is meaningful only when rsp_valid_o=1.

Optional Feature:
Macro ALU_SHIFT_ROTATE_EN.
- Defined: op 11 = ROR. Each BUSY step rotates right by s, with bits leaving the LSB re-entering at the MSB. err_o is never set.
- Undefined: op 11 is illegal, handled as described in Behaviour (err_o=1, rs1 passed through, latency 1).

Test Plan:
- SLL: rs1=0x0000_0001, rs2=5, use_imm=0, accept in cycle C. Required: busy_o high in C+1 and C+2; rsp_valid_o=1 in C+3; result_o=0x0000_0020; err_o=0.
- SRA: rs1=0x8000_0000, imm=31, use_imm=1. Required: rsp_valid_o in C+9; result_o=0xFFFF_FFFF. Repeat as SRL: result_o=0x0000_0001.
- Zero amount and upper-bit masking:
  - rs2=0x0000_0020 (amt=0), SLL, rs1=0xDEAD_BEEF: result_o=0xDEAD_BEEF at C+1, with no BUSY cycle.
  - rs2=0x23 (amt=3), SLL, rs1=1: result_o=0x8.
- Backpressure: hold rsp_ready_i=0 for 3 cycles in DONE. Required: rsp_valid_o, result_o and err_o stable; req_ready_o=0; a req_valid_i pulse is not accepted. After rsp_ready_i=1, req_ready_o=1 in the next cycle.
- Reset mid-operation: SLL amt=31 accepted, rst=1 in cycle C+3. Required: in C+4, IDLE, rsp_valid_o=0, result_o=0, req_ready_o=1, and no response appears afterwards.
- op=11, rs1=0x0000_00F1, amt=4:
  - macro undefined: C+1 gives err_o=1, result_o=0x0000_00F1;
  - macro defined: C+2 gives err_o=0, result_o=0x1000_000F.
